load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 28 ++
 rtl/load_store_unit_if.sv | 53 +++++
 rtl/load_store_unit_align.sv | 49 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit_pkg : shared types and helpers for the load/store unit
// Revision: 1.0
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

   // Encodings match funct3[1:0] of the load/store instructions.
   typedef enum logic [1:0] {
      BYTE      = 2'b00,
      HALF_WORD = 2'b01,
      WORD      = 2'b10,
      DOUBLE    = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } lsu_state_t;

   function automatic logic [3:0] size_bytes(input mem_size_t size);
      return 4'd1 << size;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit_if : pipeline request/response and data-memory bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   import load_store_unit_pkg::*;

   localparam int NB = XLEN / 8;

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   mem_size_t       req_size;
   logic            req_unsigned;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;

   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_misaligned;

   logic            mem_req;
   logic            mem_gnt;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [NB-1:0]   mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   // The load/store unit itself.
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_misaligned,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   // The pipeline and data memory surrounding it.
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_misaligned,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : byte-enable generation, store lane replication, load extraction
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_align
   import load_store_unit_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  mem_size_t        size,
   input  logic             is_unsigned,
   input  logic [OFF_W-1:0] offset,
   input  logic [XLEN-1:0]  data_in,
   output logic [NB-1:0]    be,
   output logic [XLEN-1:0]  lanes,
   output logic [XLEN-1:0]  ext
);

   logic [3:0]      w_bytes;
   logic [2*NB-1:0] w_be_base;
   logic [XLEN-1:0] w_shifted;
   logic [XLEN-1:0] w_mask;
   logic [XLEN-1:0] w_msb;
   logic            w_sign;

   assign w_bytes   = size_bytes(size);
   assign w_be_base = ((2*NB)'(1) << w_bytes) - (2*NB)'(1);
   assign be        = w_be_base[NB-1:0] << offset;

   // Access sizes are powers of two, so lane i takes source byte i mod size.
   always_comb begin
      lanes = '0;
      for (int i = 0; i < NB; i++) begin
         lanes[8*i +: 8] = data_in[8*(i & (32'(w_bytes) - 1)) +: 8];
      end
   end

   // A full-width mask leaves nothing to extend, which covers WORD on XLEN=32.
   assign w_shifted = data_in >> {offset, 3'b000};
   assign w_mask    = (w_bytes >= 4'(NB)) ? '1 : ((XLEN'(1) << {w_bytes, 3'b000}) - XLEN'(1));
   assign w_msb     = XLEN'(1) << ({w_bytes, 3'b000} - 7'd1);
   assign w_sign    = (|(w_shifted & w_msb)) && !is_unsigned;
   assign ext       = (w_shifted & w_mask) | (w_sign ? ~w_mask : '0);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : single-outstanding load/store unit to a data-memory port
// Revision: 1.0
// ----------------------------------------------------------------------------
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   localparam int              NB          = XLEN / 8;
   localparam int              c_OFF_W     = $clog2(NB);
   localparam logic [XLEN-1:0] c_ADDR_MASK = ~XLEN'(NB - 1);

   lsu_state_t         r_state;
   logic               r_we;
   logic               r_unsigned;
   mem_size_t          r_size;
   logic [c_OFF_W-1:0] r_offset;

   logic               r_req_ready;
   logic               r_resp_valid;
   logic [XLEN-1:0]    r_resp_rdata;
   logic               r_resp_misaligned;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [XLEN-1:0]    r_mem_addr;
   logic [NB-1:0]      r_mem_be;
   logic [XLEN-1:0]    r_mem_wdata;

   logic [3:0]         w_bytes;
   logic               w_accept;
   logic               w_misaligned;
   logic [NB-1:0]      w_st_be;
   logic [XLEN-1:0]    w_st_lanes;
   logic [XLEN-1:0]    w_st_ext_unused;
   logic [NB-1:0]      w_ld_be_unused;
   logic [XLEN-1:0]    w_ld_lanes_unused;
   logic [XLEN-1:0]    w_ld_ext;

   assign w_bytes      = size_bytes(bus.req_size);
   assign w_accept     = bus.req_valid && r_req_ready;
   assign w_misaligned = ((bus.req_addr[c_OFF_W-1:0] & c_OFF_W'(w_bytes - 4'd1)) != '0)
                         || (bus.req_size == DOUBLE && XLEN == 32);

   lsu_align #(.XLEN(XLEN)) u_store_align (
      .size        (bus.req_size),
      .is_unsigned (1'b0),
      .offset      (bus.req_addr[c_OFF_W-1:0]),
      .data_in     (bus.req_wdata),
      .be          (w_st_be),
      .lanes       (w_st_lanes),
      .ext         (w_st_ext_unused)
   );

   lsu_align #(.XLEN(XLEN)) u_load_align (
      .size        (r_size),
      .is_unsigned (r_unsigned),
      .offset      (r_offset),
      .data_in     (bus.mem_rdata),
      .be          (w_ld_be_unused),
      .lanes       (w_ld_lanes_unused),
      .ext         (w_ld_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state           <= IDLE;
         r_we              <= 1'b0;
         r_unsigned        <= 1'b0;
         r_size            <= BYTE;
         r_offset          <= '0;
         r_req_ready       <= 1'b1;
         r_resp_valid      <= 1'b0;
         r_resp_rdata      <= '0;
         r_resp_misaligned <= 1'b0;
         r_mem_req         <= 1'b0;
         r_mem_we          <= 1'b0;
         r_mem_addr        <= '0;
         r_mem_be          <= '0;
         r_mem_wdata       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_we        <= bus.req_we;
                  r_unsigned  <= bus.req_unsigned;
                  r_size      <= bus.req_size;
                  r_offset    <= bus.req_addr[c_OFF_W-1:0];
                  if (w_misaligned) begin
                     r_state           <= RESP;
                     r_resp_valid      <= 1'b1;
                     r_resp_misaligned <= 1'b1;
                     r_resp_rdata      <= '0;
                  end else begin
                     r_state     <= REQ;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= bus.req_we;
                     r_mem_addr  <= bus.req_addr & c_ADDR_MASK;
                     r_mem_be    <= w_st_be;
                     r_mem_wdata <= w_st_lanes;
                  end
               end
            end
            REQ: begin
               if (bus.mem_gnt) begin
                  r_state     <= WAIT;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_be    <= '0;
                  r_mem_wdata <= '0;
               end
            end
            WAIT: begin
               if (bus.mem_rvalid) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= r_we ? '0 : w_ld_ext;
               end
            end
            RESP: begin
               r_state           <= IDLE;
               r_req_ready       <= 1'b1;
               r_resp_valid      <= 1'b0;
               r_resp_rdata      <= '0;
               r_resp_misaligned <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready       = r_req_ready;
   assign bus.resp_valid      = r_resp_valid;
   assign bus.resp_rdata      = r_resp_rdata;
   assign bus.resp_misaligned = r_resp_misaligned;
   assign bus.mem_req         = r_mem_req;
   assign bus.mem_we          = r_mem_we;
   assign bus.mem_addr        = r_mem_addr;
   assign bus.mem_be          = r_mem_be;
   assign bus.mem_wdata       = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : directed and random accesses on XLEN=32 and XLEN=64
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk;
   logic rst;
   logic sel64;

   int n_vec;
   int n_bad;

   logic [63:0] cap_addr;
   logic [63:0] cap_be;
   logic [63:0] cap_wd;
   logic [63:0] cap_rd;
   logic [63:0] cap_mis;

   load_store_unit_if #(.XLEN(32)) bus32 ();
   load_store_unit_if #(.XLEN(64)) bus64 ();

   load_store_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   load_store_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   logic        w_req_ready;
   logic        w_resp_valid;
   logic [63:0] w_resp_rdata;
   logic        w_resp_mis;
   logic        w_mem_req;
   logic        w_mem_we;
   logic [63:0] w_mem_addr;
   logic [63:0] w_mem_be;
   logic [63:0] w_mem_wdata;

   assign w_req_ready  = sel64 ? bus64.req_ready       : bus32.req_ready;
   assign w_resp_valid = sel64 ? bus64.resp_valid      : bus32.resp_valid;
   assign w_resp_rdata = sel64 ? bus64.resp_rdata      : {32'b0, bus32.resp_rdata};
   assign w_resp_mis   = sel64 ? bus64.resp_misaligned : bus32.resp_misaligned;
   assign w_mem_req    = sel64 ? bus64.mem_req         : bus32.mem_req;
   assign w_mem_we     = sel64 ? bus64.mem_we          : bus32.mem_we;
   assign w_mem_addr   = sel64 ? bus64.mem_addr        : {32'b0, bus32.mem_addr};
   assign w_mem_be     = sel64 ? {56'b0, bus64.mem_be} : {60'b0, bus32.mem_be};
   assign w_mem_wdata  = sel64 ? bus64.mem_wdata       : {32'b0, bus32.mem_wdata};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (xlen64=%0d t=%0t)", tag, got, exp, sel64, $time);
      end
   endtask

   task automatic drive_req(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                            input logic [63:0] a, input logic [63:0] wd);
      bus32.req_valid    = v && !sel64;
      bus64.req_valid    = v && sel64;
      bus32.req_we       = we;
      bus64.req_we       = we;
      bus32.req_size     = mem_size_t'(sz);
      bus64.req_size     = mem_size_t'(sz);
      bus32.req_unsigned = uns;
      bus64.req_unsigned = uns;
      bus32.req_addr     = a[31:0];
      bus64.req_addr     = a;
      bus32.req_wdata    = wd[31:0];
      bus64.req_wdata    = wd;
   endtask

   task automatic drive_mem(input bit g, input bit rv, input logic [63:0] rd);
      bus32.mem_gnt    = g && !sel64;
      bus64.mem_gnt    = g && sel64;
      bus32.mem_rvalid = rv && !sel64;
      bus64.mem_rvalid = rv && sel64;
      bus32.mem_rdata  = rd[31:0];
      bus64.mem_rdata  = rd;
   endtask

   function automatic logic [63:0] byte_mask(input int bytes);
      return (bytes >= 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
   endfunction

   // Reference load: pick the addressed bytes, then sign- or zero-extend.
   function automatic logic [63:0] ref_load(input bit is64, input int bytes, input bit uns,
                                            input logic [63:0] addr, input logic [63:0] rdata);
      logic [63:0] v;
      logic [63:0] m;
      int          nb;
      nb = is64 ? 8 : 4;
      v  = rdata >> (8 * (addr % nb));
      m  = byte_mask(bytes);
      v  = v & m;
      if (bytes < 8 && !uns && v[8*bytes-1]) v = v | ~m;
      if (!is64) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic access(input bit is64, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr_in, input logic [63:0] wdata_in,
                         input logic [63:0] rdata_in, input int gnt_dly, input int rv_dly);
      logic [63:0] addr, wdata, rdata;
      logic [63:0] exp_addr, exp_be, exp_wd, exp_rd;
      int          nb, bytes, off;
      bit          mis;
      addr  = addr_in;
      wdata = wdata_in;
      rdata = rdata_in;
      if (!is64) begin
         addr[63:32]  = '0;
         wdata[63:32] = '0;
         rdata[63:32] = '0;
      end
      nb       = is64 ? 8 : 4;
      bytes    = 1 << sz;
      off      = int'(addr % nb);
      mis      = (addr % bytes != 0) || (sz == 2'd3 && !is64);
      exp_addr = addr - 64'(off);
      exp_be   = ((64'd1 << bytes) - 64'd1) << off;
      exp_wd   = '0;
      for (int k = 0; k < nb; k += bytes) exp_wd = exp_wd | ((wdata & byte_mask(bytes)) << (8 * k));
      exp_rd   = we ? 64'd0 : ref_load(is64, bytes, uns, addr, rdata);

      sel64 = is64;
      @(negedge clk);
      chk_val("ready_idle", 64'(w_req_ready), 64'd1);
      drive_req(1'b1, we, sz, uns, addr, wdata);
      @(posedge clk);
      #1;
      // Keep a competing request asserted while busy; it must not be taken.
      drive_req(1'b1, $urandom_range(0, 1), 2'($urandom), 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      if (mis) begin
         chk_val("mis_resp_valid", 64'(w_resp_valid), 64'd1);
         chk_val("mis_flag", 64'(w_resp_mis), 64'd1);
         chk_val("mis_rdata", w_resp_rdata, 64'd0);
         chk_val("mis_mem_req", 64'(w_mem_req), 64'd0);
         cap_mis = 64'(w_resp_mis);
         cap_rd  = w_resp_rdata;
         drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
         @(negedge clk);
         chk_val("mis_done", {61'd0, w_resp_valid, w_req_ready, w_mem_req}, 64'b010);
         return;
      end
      chk_val("req_cycle", {61'd0, w_mem_req, w_req_ready, w_resp_valid}, 64'b100);
      chk_val("mem_we", 64'(w_mem_we), 64'(we));
      chk_val("mem_addr", w_mem_addr, exp_addr);
      chk_val("mem_be", w_mem_be, exp_be);
      if (we) chk_val("mem_wdata", w_mem_wdata, exp_wd);
      cap_addr = w_mem_addr;
      cap_be   = w_mem_be;
      cap_wd   = w_mem_wdata;
      for (int i = 0; i < gnt_dly; i++) begin
         drive_mem(1'b0, $urandom_range(0, 1), {$urandom, $urandom});
         @(negedge clk);
         drive_mem(1'b0, 1'b0, 64'd0);
         chk_val("stall_ctrl", {61'd0, w_mem_req, w_req_ready, w_resp_valid}, 64'b100);
         chk_val("stall_addr", w_mem_addr, exp_addr);
      end
      drive_mem(1'b1, 1'b0, 64'd0);
      @(negedge clk);
      drive_mem(1'b0, 1'b0, 64'd0);
      chk_val("wait_mem_req", 64'(w_mem_req), 64'd0);
      for (int i = 0; i < rv_dly; i++) begin
         drive_mem($urandom_range(0, 1), 1'b0, 64'd0);
         @(negedge clk);
         drive_mem(1'b0, 1'b0, 64'd0);
         chk_val("wait_idle", {62'd0, w_resp_valid, w_req_ready}, 64'b00);
      end
      drive_mem(1'b0, 1'b1, rdata);
      @(negedge clk);
      drive_mem(1'b0, 1'b0, {$urandom, $urandom});
      chk_val("resp_valid", 64'(w_resp_valid), 64'd1);
      chk_val("resp_mis", 64'(w_resp_mis), 64'd0);
      chk_val("resp_rdata", w_resp_rdata, exp_rd);
      cap_rd  = w_resp_rdata;
      cap_mis = 64'(w_resp_mis);
      drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      @(negedge clk);
      chk_val("resp_done", {62'd0, w_resp_valid, w_req_ready}, 64'b01);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk_val({tag, "_ready"}, 64'(w_req_ready), 64'd1);
      chk_val({tag, "_outs"}, {60'd0, w_resp_valid, w_resp_mis, w_mem_req, w_mem_we}, 64'd0);
      chk_val({tag, "_rdata"}, w_resp_rdata, 64'd0);
      chk_val({tag, "_addr"}, w_mem_addr, 64'd0);
      chk_val({tag, "_be"}, w_mem_be, 64'd0);
      chk_val({tag, "_wdata"}, w_mem_wdata, 64'd0);
   endtask

   initial begin
      logic [63:0] r64;
      logic [63:0] a;
      logic [1:0]  sz;
      n_vec = 0;
      n_bad = 0;
      sel64 = 1'b0;
      rst   = 1'b1;
      drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      drive_mem(1'b0, 1'b0, 64'd0);
      repeat (3) @(negedge clk);
      sel64 = 1'b0;
      #1 chk_reset_outs("reset32");
      sel64 = 1'b1;
      #1 chk_reset_outs("reset64");
      @(negedge clk);
      rst = 1'b0;

      // LB / LBU from the top byte lane.
      access(1'b0, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'h80FF_FF00, 0, 0);
      chk_val("lb_be", cap_be, 64'b1000);
      chk_val("lb_addr", cap_addr, 64'h1000);
      chk_val("lb_rdata", cap_rd, 64'hFFFF_FF80);
      access(1'b0, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h80FF_FF00, 0, 0);
      chk_val("lbu_rdata", cap_rd, 64'h0000_0080);

      // SH to the upper half-word.
      access(1'b0, 1'b1, 2'd1, 1'b0, 64'h2002, 64'h1234_ABCD, 64'h5555_5555, 0, 1);
      chk_val("sh_be", cap_be, 64'b1100);
      chk_val("sh_wdata", cap_wd, 64'hABCD_ABCD);
      chk_val("sh_rdata", cap_rd, 64'd0);

      // Misaligned word and DOUBLE on XLEN=32.
      access(1'b0, 1'b0, 2'd2, 1'b0, 64'h3001, 64'd0, 64'd0, 0, 0);
      chk_val("lw_mis", cap_mis, 64'd1);
      access(1'b0, 1'b1, 2'd3, 1'b0, 64'h4000, 64'hDEAD, 64'd0, 0, 0);
      chk_val("dbl_mis", cap_mis, 64'd1);

      // Five-cycle grant stall.
      access(1'b0, 1'b0, 2'd2, 1'b0, 64'h100, 64'd0, 64'hCAFE_F00D, 5, 2);
      chk_val("stall_rdata", cap_rd, 64'hCAFE_F00D);

      // Reset while waiting for read data, then a late rvalid.
      sel64 = 1'b0;
      @(negedge clk);
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'd0);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
      drive_mem(1'b1, 1'b0, 64'd0);
      @(negedge clk);
      drive_mem(1'b0, 1'b0, 64'd0);
      chk_val("pre_rst_busy", 64'(w_req_ready), 64'd0);
      rst = 1'b1;
      #1 chk_val("rst_async_ready", 64'(w_req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      drive_mem(1'b0, 1'b1, 64'h1234_5678);
      @(negedge clk);
      drive_mem(1'b0, 1'b0, 64'd0);
      chk_val("post_rst", {62'd0, w_resp_valid, w_req_ready}, 64'b01);
      @(negedge clk);
      chk_val("post_rst_quiet", {62'd0, w_resp_valid, w_mem_req}, 64'b00);

      // XLEN=64: LD passes through, LWU of the upper half zero-extends.
      r64 = {$urandom, $urandom};
      access(1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'd0, r64, 1, 0);
      chk_val("ld_rdata", cap_rd, r64);
      access(1'b1, 1'b0, 2'd2, 1'b1, 64'hC, 64'd0, 64'hFFFF_FFFF_0000_1234, 0, 0);
      chk_val("lwu_rdata", cap_rd, 64'h0000_0000_FFFF_FFFF);
      chk_val("lwu_be", cap_be, 64'hF0);

      for (int n = 0; n < 300; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
         access(n[0], 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
